compressor_cpa_pipe: RTL and testbench
======================================

// Module: compressor_cpa_pipe
// PURPOSE
//  Final carry-propagate stage downstream of a W-bit row of 4:2 compressors.
//  Consumes the row's sum vector, carry vector (bit i weighs 2^(i+1)) and top cout (weighs 2^W).
//  Produces the binary value V = sum + 2*carry + 2^W*cout.
//  Two-stage pipelined adder split at bit SPLIT, with valid/ready handshake on both sides.
// PARAMETERS
//  W      8   compressor row width; result is W+2 bits
//  SPLIT  4   bits resolved in stage 1 (2 <= SPLIT <= W-1); stage 2 resolves the rest
//  TAG_W  4   sideband tag width, carried alongside each operand set
//  CNT_W  16  width of completed-result counter
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        operand set present
//  in_ready   out  1        stage 1 can accept this cycle
//  in_sum     in   W        compressor sum vector
//  in_carry   in   W        compressor carry vector (weight shifted by 1)
//  in_cout    in   1        top cout of compressor row
//  in_tag     in   TAG_W    sideband tag
//  out_valid  out  1        result present
//  out_ready  in   1        consumer accepts
//  out_result out  W+2      V
//  out_tag    out  TAG_W    tag of the set that produced out_result
//  done_cnt   out  CNT_W    number of output handshakes since reset
// BEHAVIOUR
//  Reset (async, immediate): s1_valid=0, s2_valid=0, out_valid=0.
//   out_result=0, out_tag=0, done_cnt=0; all in-flight data discarded.
//   in_ready is 1 in the first cycle after reset releases.
//  Stage 1 on load (in_valid & in_ready):
//   {c1, lo} = in_sum[SPLIT-1:0] + {in_carry[SPLIT-2:0], 1'b0}; lo is SPLIT bits.
//   Registers lo, c1, in_sum[W-1:SPLIT], in_carry[W-1:SPLIT-1], in_cout, in_tag.
//  Stage 2 on load from stage 1:
//   hi = sum_hi + carry_hi + (cout << (W-SPLIT)) + c1; hi is W+2-SPLIT bits.
//   Registers out_result = {hi, lo} and out_tag. No truncation: max V = 2^(W+2)-3.
//  Handshake and flow control:
//   adv2 = s1_valid & (~s2_valid | out_ready); in_ready = ~s1_valid | adv2.
//   in_ready is combinational from out_ready and the state; it does not depend on in_valid.
//   Output handshake (out_valid & out_ready) with no adv2 clears s2_valid.
//   Simultaneous output handshake and adv2: s2 is replaced in the same cycle (no bubble).
//   Simultaneous in load and adv2: s1 is replaced in the same cycle.
//  Latency and throughput:
//   Latency is 2 cycles: data loaded at edge N is on out_result after edge N+1.
//   Throughput is 1 result/cycle while out_ready=1.
//  Stall and hold:
//   While out_valid & ~out_ready: out_result and out_tag are held stable.
//   Stage 1 holds once s2 is full. At most 2 sets are in flight.
//  in_* values are ignored when no load occurs. X on in_* without in_valid must not propagate.
//  done_cnt increments on each output handshake and wraps modulo 2^CNT_W.
//  Reset asserted mid-transfer drops both stages; no partial result is ever presented.
// TESTING (W=8, SPLIT=4)
//  1. Reset, out_ready=1; load sum=0x0F carry=0x08 cout=0 tag=3.
//     -> out_valid 2 cycles later, result=0x01F, tag=3, done_cnt=1.
//  2. sum=0xFF carry=0xFF cout=1 -> result=0x3FD (max carry through split and top bit).
//  3. Back-to-back stream of 8 sets, out_ready=1 -> 8 consecutive out_valid cycles.
//     Results are in order and match the model; in_ready stays 1.
//  4. out_ready=0 for 5 cycles while 4 sets are offered.
//     -> in_ready drops after 2 loads; out_result held; release yields sets in order, none lost.
//  5. Assert rst with 2 sets in flight -> out_valid=0 and done_cnt=0 immediately.
//     A fresh set after release returns the correct result.
//  6. Random sum/carry/cout/out_ready for 10k cycles vs reference V.
//     -> zero mismatches; done_cnt equals the handshake count mod 2^16.

Source files
------------

// File: rtl/compressor_cpa_pipe.sv
// Two-stage pipelined carry-propagate adder for a 4:2 compressor row: V = sum + 2*carry + 2^W*cout.
// Stage 1 resolves the low SPLIT bits, stage 2 the upper bits; valid/ready on both sides.
module compressor_cpa_pipe #(
  parameter int W     = 8,
  parameter int SPLIT = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_sum,
  input  logic [W-1:0]     in_carry,
  input  logic             in_cout,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W+1:0]     out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int SHW = W - SPLIT;
  localparam int HW  = W + 2 - SPLIT;

  logic             s1_valid_q, s1_valid_d;
  logic [SPLIT-1:0] s1_lo_q;
  logic             s1_c1_q;
  logic [SHW-1:0]   s1_sum_hi_q;
  logic [SHW:0]     s1_carry_hi_q;
  logic             s1_cout_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q, s2_valid_d;
  logic [W+1:0]     result_q;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic             adv2, load1, out_fire;
  logic [SPLIT:0]   lo_full;
  logic [HW-1:0]    hi;

  always_comb begin
    adv2     = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready = ~s1_valid_q | adv2;
    load1    = in_valid & in_ready;
    out_fire = s2_valid_q & out_ready;
  end

  // Carry vector bit i weighs 2^(i+1), so only carry[SPLIT-2:0] lands in the low field.
  assign lo_full = {1'b0, in_sum[SPLIT-1:0]} + {1'b0, in_carry[SPLIT-2:0], 1'b0};

  assign hi = {2'b00, s1_sum_hi_q}
            + {1'b0, s1_carry_hi_q}
            + {1'b0, s1_cout_q, {SHW{1'b0}}}
            + {{(HW-1){1'b0}}, s1_c1_q};

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (load1)     s1_valid_d = 1'b1;
    else if (adv2) s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (adv2)          s2_valid_d = 1'b1;
    else if (out_fire) s2_valid_d = 1'b0;

    done_cnt_d = done_cnt_q + (out_fire ? CNT_W'(1) : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_lo_q       <= '0;
      s1_c1_q       <= 1'b0;
      s1_sum_hi_q   <= '0;
      s1_carry_hi_q <= '0;
      s1_cout_q     <= 1'b0;
      s1_tag_q      <= '0;
      s2_valid_q    <= 1'b0;
      result_q      <= '0;
      tag_q         <= '0;
      done_cnt_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      done_cnt_q <= done_cnt_d;
      if (load1) begin
        s1_lo_q       <= lo_full[SPLIT-1:0];
        s1_c1_q       <= lo_full[SPLIT];
        s1_sum_hi_q   <= in_sum[W-1:SPLIT];
        s1_carry_hi_q <= in_carry[W-1:SPLIT-1];
        s1_cout_q     <= in_cout;
        s1_tag_q      <= in_tag;
      end
      if (adv2) begin
        result_q <= {hi, s1_lo_q};
        tag_q    <= s1_tag_q;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = result_q;
  assign out_tag    = tag_q;
  assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_compressor_cpa_pipe.sv
// Randomized and directed bench for compressor_cpa_pipe against an arithmetic reference queue.
module tb_compressor_cpa_pipe;

  localparam int W = 8;
  localparam int SPLIT = 4;
  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_sum;
  logic [W-1:0]     in_carry;
  logic             in_cout;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W+1:0]     out_result;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] done_cnt;

  compressor_cpa_pipe #(.W(W), .SPLIT(SPLIT), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_cout(in_cout), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .done_cnt(done_cnt)
  );

  typedef struct {
    logic [W+1:0]     v;
    logic [TAG_W-1:0] tag;
    int               le;
  } item_t;

  item_t q[$];
  int checks = 0;
  int failures = 0;
  int ecnt = 0;
  int hcount = 0;
  bit acc;
  bit held = 0;
  logic [W+1:0]     prev_res, last_res;
  logic [TAG_W-1:0] prev_tag, last_tag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] model_v(input logic [W-1:0] s, input logic [W-1:0] c,
                                           input logic co);
    int v;
    v = int'(s) + 2 * int'(c) + (co ? (1 << W) : 0);
    return v[W+1:0];
  endfunction

  task automatic drive(input logic [W-1:0] s, input logic [W-1:0] c, input logic co,
                       input logic [TAG_W-1:0] t);
    in_valid = 1'b1; in_sum = s; in_carry = c; in_cout = co; in_tag = t;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_sum = 'x; in_carry = 'x; in_cout = 1'bx; in_tag = 'x;
  endtask

  task automatic drive_rand();
    drive(W'($urandom), W'($urandom), 1'($urandom), TAG_W'($urandom));
  endtask

  // Called at a falling edge with inputs set; samples just before the rising edge.
  task automatic step();
    bit exp_ov;
    item_t it;
    #4;
    exp_ov = (q.size() > 0) && (q[0].le + 1 <= ecnt);
    check("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
    check("out_valid", 64'(out_valid), 64'(exp_ov));
    check("done_cnt", 64'(done_cnt), 64'(hcount % (1 << CNT_W)));
    if (held && out_valid) begin
      check("hold_res", 64'(out_result), 64'(prev_res));
      check("hold_tag", 64'(out_tag), 64'(prev_tag));
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out", 64'(out_valid), 64'(0));
      end else begin
        it = q.pop_front();
        check("result", 64'(out_result), 64'(it.v));
        check("tag", 64'(out_tag), 64'(it.tag));
      end
      hcount++;
      last_res = out_result;
      last_tag = out_tag;
    end
    acc = in_valid && in_ready;
    if (acc) begin
      it.v = model_v(in_sum, in_carry, in_cout);
      it.tag = in_tag;
      it.le = ecnt + 1;
      q.push_back(it);
    end
    held = out_valid && !out_ready;
    prev_res = out_result;
    prev_tag = out_tag;
    @(posedge clk);
    ecnt++;
    #5;
  endtask

  task automatic drain(input int max);
    int n;
    out_ready = 1'b1;
    idle();
    n = 0;
    while (q.size() > 0 && n < max) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(q.size()), 64'(0));
  endtask

  initial begin
    int base, offered;
    logic [W-1:0] s4 [4];
    logic [W-1:0] c4 [4];

    rst = 1'b1;
    out_ready = 1'b1;
    idle();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_done_cnt", 64'(done_cnt), 64'(0));
    check("rst_result", 64'(out_result), 64'(0));
    check("rst_tag", 64'(out_tag), 64'(0));
    #9;
    rst = 1'b0;

    // 1: basic set and latency
    drive(8'h0F, 8'h08, 1'b0, 4'd3);
    step();
    idle();
    drain(10);
    check("t1_res", 64'(last_res), 64'h01F);
    check("t1_tag", 64'(last_tag), 64'd3);
    check("t1_cnt", 64'(done_cnt), 64'd1);

    // 2: maximum value, carry across the split and into the top bits
    drive(8'hFF, 8'hFF, 1'b1, 4'd5);
    step();
    idle();
    drain(10);
    check("t2_res", 64'(last_res), 64'h3FD);

    // 3: back-to-back stream
    base = hcount;
    for (int i = 0; i < 8; i++) begin
      drive_rand();
      step();
    end
    idle();
    step();
    step();
    check("t3_cnt", 64'(hcount - base), 64'd8);

    // 4: stall with 4 sets offered
    base = hcount;
    for (int i = 0; i < 4; i++) begin
      s4[i] = W'($urandom);
      c4[i] = W'($urandom);
    end
    out_ready = 1'b0;
    offered = 0;
    for (int i = 0; i < 5; i++) begin
      drive(s4[offered], c4[offered], 1'b0, TAG_W'(offered + 8));
      step();
      if (acc) offered++;
    end
    check("t4_loads", 64'(offered), 64'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && offered < 4; i++) begin
      drive(s4[offered], c4[offered], 1'b1, TAG_W'(offered + 8));
      step();
      if (acc) offered++;
    end
    check("t4_offered", 64'(offered), 64'd4);
    drain(10);
    check("t4_cnt", 64'(hcount - base), 64'd4);

    // 5: reset with two sets in flight
    out_ready = 1'b0;
    offered = 0;
    for (int i = 0; i < 10 && offered < 2; i++) begin
      drive_rand();
      step();
      if (acc) offered++;
    end
    idle();
    rst = 1'b1;
    #1;
    check("t5_out_valid", 64'(out_valid), 64'(0));
    check("t5_done_cnt", 64'(done_cnt), 64'(0));
    check("t5_in_ready", 64'(in_ready), 64'(1));
    q.delete();
    hcount = 0;
    held = 0;
    @(posedge clk);
    ecnt++;
    #5;
    rst = 1'b0;
    out_ready = 1'b1;
    drive(8'hA5, 8'h3C, 1'b1, 4'd7);
    step();
    drain(10);
    check("t5_res", 64'(last_res), 64'(model_v(8'hA5, 8'h3C, 1'b1)));
    check("t5_cnt", 64'(done_cnt), 64'd1);

    // 6: random traffic and backpressure
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) != 0) drive_rand();
      else idle();
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(20);
    check("t6_done_cnt", 64'(done_cnt), 64'(hcount % (1 << CNT_W)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
